// File: rtl/layer3_dense_if.sv
// Bus bundle for layer3_dense: activation handshake in, results out, and the
// weight-ROM read port. The DUT takes the slave side, the upstream/host the master side.
interface layer3_dense_if #(
  parameter int N_IN   = 32,
  parameter int N_OUT  = 16,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int AW     = $clog2(N_OUT * (N_IN + 1))
);
  logic                     valid_in;
  logic signed [DATA_W-1:0] input_data  [0:N_IN-1];
  logic                     ready_out;
  logic        [AW-1:0]     w_addr;
  logic signed [COEF_W-1:0] w_data;
  logic signed [DATA_W-1:0] output_data [0:N_OUT-1];
  logic                     valid_out;

  modport master (
    output valid_in,
    output input_data,
    output w_data,
    input  ready_out,
    input  w_addr,
    input  output_data,
    input  valid_out
  );

  modport slave (
    input  valid_in,
    input  input_data,
    input  w_data,
    output ready_out,
    output w_addr,
    output output_data,
    output valid_out
  );
endinterface

// File: rtl/layer3_dense.sv
// Fully-connected layer with one shared MAC: N_OUT rows of N_IN weights plus a
// bias are streamed from a synchronous ROM and accumulated, then saturated/ReLU'd.
module layer3_dense #(
  parameter int N_IN      = 32,
  parameter int N_OUT     = 16,
  parameter int FRAC_BITS = 8,
  parameter int RELU      = 1,
  parameter int ACC_W     = 40,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16
) (
  input  logic         clk,
  input  logic         reset,
  layer3_dense_if.slave bus
);

  localparam int AW = $clog2(N_OUT * (N_IN + 1));
  localparam int KW = $clog2(N_IN + 1);
  localparam int OW = $clog2(N_OUT + 1);
  localparam int PW = DATA_W + COEF_W;

  localparam logic signed [DATA_W-1:0] ONE_Q  = DATA_W'(1 << FRAC_BITS);
  localparam logic signed [ACC_W-1:0]  SAT_HI = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0]  SAT_LO = ~SAT_HI;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_STORE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                     w_accept;
  logic                     w_ready;
  logic                     w_vout;

  logic signed [DATA_W-1:0] r_x   [0:N_IN-1];
  logic signed [DATA_W-1:0] r_res [0:N_OUT-1];
  logic signed [DATA_W-1:0] r_out [0:N_OUT-1];

  logic        [KW-1:0]     r_k;
  logic        [OW-1:0]     r_o;
  logic        [AW-1:0]     r_addr;

  logic                     r_vld_p1;
  logic        [KW-1:0]     r_idx_p1;
  logic signed [ACC_W-1:0]  r_acc;

  logic signed [DATA_W-1:0] w_x_sel;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [DATA_W-1:0] w_res;
  logic                     w_last_row;

  function automatic logic signed [DATA_W-1:0] sat_q(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI) begin
      sat_q = SAT_HI[DATA_W-1:0];
    end else if (v < SAT_LO) begin
      sat_q = SAT_LO[DATA_W-1:0];
    end else begin
      sat_q = v[DATA_W-1:0];
    end
  endfunction

  function automatic logic signed [DATA_W-1:0] relu_q(input logic signed [DATA_W-1:0] v);
    if ((RELU != 0) && v[DATA_W-1]) begin
      relu_q = '0;
    end else begin
      relu_q = v;
    end
  endfunction

  // Control: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_last_row = (r_o == OW'(N_OUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ready     = 1'b0;
    w_vout      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.valid_in) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_k == KW'(N_IN)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_STORE;
      end
      S_STORE: begin
        w_state_nxt = w_last_row ? S_DONE : S_RUN;
      end
      S_DONE: begin
        w_vout      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Stage p1: the ROM word for index r_idx_p1 is on w_data; the bias slot uses 1.0
  always_comb begin
    w_x_sel = ONE_Q;
    for (int j = 0; j < N_IN; j++) begin
      if (r_idx_p1 == KW'(j)) begin
        w_x_sel = r_x[j];
      end
    end
  end

  assign w_prod  = PW'(w_x_sel) * PW'(bus.w_data);
  assign w_shift = r_acc >>> FRAC_BITS;
  assign w_res   = relu_q(sat_q(w_shift));

  // Stage p0 (address issue / counters) and p1 (accumulate / store)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < N_IN; j++) begin
        r_x[j] <= '0;
      end
      for (int j = 0; j < N_OUT; j++) begin
        r_res[j] <= '0;
        r_out[j] <= '0;
      end
      r_k      <= '0;
      r_o      <= '0;
      r_addr   <= '0;
      r_vld_p1 <= 1'b0;
      r_idx_p1 <= '0;
      r_acc    <= '0;
    end else begin
      r_vld_p1 <= 1'b0;

      if (w_accept) begin
        for (int j = 0; j < N_IN; j++) begin
          r_x[j] <= bus.input_data[j];
        end
        r_k    <= '0;
        r_o    <= '0;
        r_addr <= '0;
        r_acc  <= '0;
      end

      // The address counter runs across row boundaries, so it lands on the next row base
      if (r_state == S_RUN) begin
        r_vld_p1 <= 1'b1;
        r_idx_p1 <= r_k;
        r_addr   <= r_addr + AW'(1);
        r_k      <= (r_k == KW'(N_IN)) ? '0 : r_k + KW'(1);
      end

      if (r_state == S_STORE) begin
        r_acc <= '0;
        for (int j = 0; j < N_OUT; j++) begin
          if (r_o == OW'(j)) begin
            r_res[j] <= w_res;
          end
        end
        if (w_last_row) begin
          r_o <= '0;
          for (int j = 0; j < N_OUT; j++) begin
            r_out[j] <= (j == N_OUT - 1) ? w_res : r_res[j];
          end
        end else begin
          r_o <= r_o + OW'(1);
        end
      end else if (r_vld_p1) begin
        r_acc <= r_acc + ACC_W'(w_prod);
      end

      if (r_state == S_DONE) begin
        r_addr <= '0;
      end
    end
  end

  assign bus.ready_out = w_ready;
  assign bus.valid_out = w_vout;
  assign bus.w_addr    = r_addr;

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign bus.output_data[g] = r_out[g];
  end

endmodule
